// File: rtl/mem_stage_block_pkg.sv
// Shared types and constants for the MIPS MEM stage: FSM states, wait-counter
// width, default acknowledge timeout and the write-back data selector.
package mem_stage_block_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  localparam int CNT_W           = 8;
  localparam int ACK_TIMEOUT_DEF = 64;

  function automatic logic [31:0] mux2(input logic sel, input logic [31:0] in0,
                                       input logic [31:0] in1);
    return sel ? in1 : in0;
  endfunction

endpackage

// File: rtl/mem_stage_block_if.sv
// Request/acknowledge data-memory bus between the MEM stage (master) and data
// memory (slave).
interface mem_stage_block_if;
  logic        DMem_Req;
  logic        DMem_We;
  logic [31:0] DMem_Addr;
  logic [31:0] DMem_WData;
  logic [31:0] DMem_RData;
  logic        DMem_Ack;

  modport master(output DMem_Req, DMem_We, DMem_Addr, DMem_WData,
                 input DMem_RData, DMem_Ack);
  modport slave(input DMem_Req, DMem_We, DMem_Addr, DMem_WData,
                output DMem_RData, DMem_Ack);
endinterface

// File: rtl/mem_stage_block_mem_wb_stage.sv
// MEM/WB pipeline register: loads when enabled, otherwise inserts a bubble by
// clearing the write-back controls while holding data, destination and debug copy.
module mem_wb_stage
  import mem_stage_block_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        reg_write_in,
  input  logic        mem_to_reg_in,
  input  logic [31:0] alu_out_in,
  input  logic [31:0] rdata_in,
  input  logic [31:0] instr_in,
  input  logic [4:0]  dest_in,
  output logic [31:0] write_data,
  output logic [31:0] instr_out,
  output logic [4:0]  dest_out,
  output logic        reg_write,
  output logic        mem_to_reg
);

  logic [31:0] write_data_d, write_data_q;
  logic [31:0] instr_d, instr_q;
  logic [4:0]  dest_d, dest_q;
  logic        reg_write_d, reg_write_q;
  logic        mem_to_reg_d, mem_to_reg_q;

  always_comb begin
    write_data_d = write_data_q;
    instr_d      = instr_q;
    dest_d       = dest_q;
    reg_write_d  = 1'b0;
    mem_to_reg_d = 1'b0;
    if (wr_en) begin
      write_data_d = mux2(mem_to_reg_in, alu_out_in, rdata_in);
      instr_d      = instr_in;
      dest_d       = dest_in;
      reg_write_d  = reg_write_in;
      mem_to_reg_d = mem_to_reg_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      write_data_q <= '0;
      instr_q      <= '0;
      dest_q       <= '0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else begin
      write_data_q <= write_data_d;
      instr_q      <= instr_d;
      dest_q       <= dest_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
    end
  end

  assign write_data = write_data_q;
  assign instr_out  = instr_q;
  assign dest_out   = dest_q;
  assign reg_write  = reg_write_q;
  assign mem_to_reg = mem_to_reg_q;

endmodule

// File: rtl/mem_stage_block.sv
// MEM stage of the 5-stage MIPS pipeline: word load/store over a req/ack bus
// with upstream stall, alignment check, acknowledge timeout and MEM/WB register.
module mem_stage_block
  import mem_stage_block_pkg::*;
#(
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [31:0]         MEM_ALUOut,
  input  logic [31:0]         MEM_RtData,
  input  logic [31:0]         MEM_Instruction,
  input  logic [4:0]          MEM_DestReg,
  input  logic                MEM_RegWrite,
  input  logic                MEM_MemtoReg,
  input  logic                MEM_MemRead,
  input  logic                MEM_MemWrite,
  mem_stage_block_if.master   dmem,
  output logic                MEM_Stall,
  output logic [31:0]         WB_WriteData,
  output logic [4:0]          WB_DestReg,
  output logic                WB_RegWrite,
  output logic                WB_MemtoReg,
  output logic [31:0]         WB_Instruction,
  output logic                MEM_AddrError,
  output logic                MEM_BusError
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(ACK_TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d, wdata_q, wdata_d;
  logic             we_q, we_d;
  logic             addr_err_q, addr_err_d, bus_err_q, bus_err_d;

  logic access, misaligned, idle_req, in_wait, req, ack, timeout_abort;

  assign access        = MEM_MemRead | MEM_MemWrite;
  assign misaligned    = access & (MEM_ALUOut[1:0] != 2'b00);
  assign in_wait       = (state_q == S_WAIT);
  assign idle_req      = ~in_wait & access & ~misaligned;
  assign req           = ~Reset & (idle_req | in_wait);
  assign ack           = req & dmem.DMem_Ack;
  assign timeout_abort = req & in_wait & ~dmem.DMem_Ack & (cnt_q == TIMEOUT_CNT);
  assign MEM_Stall     = req & ~ack & ~timeout_abort;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    addr_err_d = misaligned & ~in_wait;
    bus_err_d  = timeout_abort;
    case (state_q)
      S_IDLE: begin
        if (idle_req) begin
          addr_d  = {MEM_ALUOut[31:2], 2'b00};
          wdata_d = MEM_RtData;
          we_d    = MEM_MemWrite;
          if (!dmem.DMem_Ack) begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      S_WAIT: begin
        // ack has priority over a timeout landing in the same cycle
        if (ack || timeout_abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      addr_err_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      addr_err_q <= addr_err_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // While waiting, the bus is driven from the latches so it stays stable.
  assign dmem.DMem_Req   = req;
  assign dmem.DMem_Addr  = in_wait ? addr_q : {MEM_ALUOut[31:2], 2'b00};
  assign dmem.DMem_WData = in_wait ? wdata_q : MEM_RtData;
  assign dmem.DMem_We    = req & (in_wait ? we_q : MEM_MemWrite);

  assign MEM_AddrError = addr_err_q;
  assign MEM_BusError  = bus_err_q;

  mem_wb_stage u_mem_wb (
    .clk          (Clock),
    .rst          (Reset),
    .wr_en        (~MEM_Stall),
    .reg_write_in (MEM_RegWrite & ~misaligned & ~timeout_abort),
    .mem_to_reg_in(MEM_MemtoReg),
    .alu_out_in   (MEM_ALUOut),
    .rdata_in     (dmem.DMem_RData),
    .instr_in     (MEM_Instruction),
    .dest_in      (MEM_DestReg),
    .write_data   (WB_WriteData),
    .instr_out    (WB_Instruction),
    .dest_out     (WB_DestReg),
    .reg_write    (WB_RegWrite),
    .mem_to_reg   (WB_MemtoReg)
  );

endmodule
